serial_io_unit: RTL

Parametrised full-duplex serial port for the pipelined RISC core. It replaces bit-banged serial I/O through the carry flag with a hardware shifter. Each direction has a FIFO, a programmable bit-rate divider and a selectable bit order. It sits on the data-memory side of the processor: the core pushes TX words and pops RX words through simple strobes.

---
 rtl/serial_io_pkg.sv | 16 +
 rtl/serial_io_if.sv | 30 +++
 rtl/serial_io_unit_fifo.sv | 59 +++++
 rtl/serial_io_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_io_pkg.sv
// serial_io_pkg: shared encodings for the serial I/O unit.
// FSM state type and line-level constants for TX/RX framing.
package serial_io_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_io_if.sv
// serial_io_if: core-side strobe bus of the serial I/O unit.
// master = core (push TX, pop RX, clear overrun); slave = unit.
interface serial_io_if #(
  parameter int DATA_W = 16
);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              tx_full;
  logic              tx_busy;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rx_empty;
  logic              rx_overrun;
  logic              frame_err;
  logic              clr_ovr;

  modport master (
    output wr_en, wr_data, rd_en, clr_ovr,
    input  tx_full, tx_busy, rd_data,
    input  rx_empty, rx_overrun, frame_err
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_ovr,
    output tx_full, tx_busy, rd_data,
    output rx_empty, rx_overrun, frame_err
  );

endinterface

// File: rtl/serial_io_unit_fifo.sv
// sync_fifo: show-ahead synchronous FIFO, registered pointers.
// push_i/wdata_i write, pop_i/rdata_o read, full_o/empty_o status.
module sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // a pop in the same cycle frees the slot for a push on a full FIFO
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    if (do_push & ~do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop & ~do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/serial_io_unit.sv
// serial_io_unit: full-duplex framed serial port with TX/RX FIFOs.
// Ports: clk, reset (async low), div, lsb_first, serial_in/out, bus.
module serial_io_unit
  import serial_io_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             lsb_first,
  input  logic             serial_in,
  output logic             serial_out,
  serial_io_if.slave       bus
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  // ---------------- TX ----------------
  state_e            tx_q, tx_d;
  logic [DIV_W-1:0]  tcnt_q, tcnt_d;
  logic [DIV_W-1:0]  tdiv_q, tdiv_d;
  logic [BW-1:0]     tbit_q, tbit_d;
  logic [DATA_W-1:0] tsh_q, tsh_d;
  logic              tlsb_q, tlsb_d;
  logic              sout_q, sout_d;
  logic              ttick, tx_pop, tx_empty, tx_full_w;
  logic [DATA_W-1:0] tx_head;

  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.wr_en),
    .wdata_i (bus.wr_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full_w),
    .empty_o (tx_empty)
  );

  assign ttick = (tcnt_q == tdiv_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q   <= IDLE;
      tcnt_q <= '0;
      tdiv_q <= '0;
      tbit_q <= '0;
      tsh_q  <= '0;
      tlsb_q <= 1'b0;
      sout_q <= IDLE_LEVEL;
    end else begin
      tx_q   <= tx_d;
      tcnt_q <= tcnt_d;
      tdiv_q <= tdiv_d;
      tbit_q <= tbit_d;
      tsh_q  <= tsh_d;
      tlsb_q <= tlsb_d;
      sout_q <= sout_d;
    end
  end

  always_comb begin
    tx_d   = tx_q;
    tcnt_d = tcnt_q + 1'b1;
    tdiv_d = tdiv_q;
    tbit_d = tbit_q;
    tsh_d  = tsh_q;
    tlsb_d = tlsb_q;
    unique case (tx_q)
      IDLE: tcnt_d = '0;
      START: begin
        if (ttick) begin
          tx_d   = DATA;
          tcnt_d = '0;
          tbit_d = '0;
        end
      end
      DATA: begin
        if (ttick) begin
          tcnt_d = '0;
          if (tbit_q == LAST_BIT) begin
            tx_d = STOP;
          end else begin
            tbit_d = tbit_q + 1'b1;
            tsh_d  = tlsb_q ? (tsh_q >> 1) : (tsh_q << 1);
          end
        end
      end
      STOP: begin
        if (ttick) begin
          tcnt_d = '0;
          tx_d   = IDLE;
        end
      end
    endcase
    // a load from IDLE or at the end of STOP chains frames with no gap
    if (tx_pop) begin
      tx_d   = START;
      tcnt_d = '0;
      tsh_d  = tx_head;
      tdiv_d = div;
      tlsb_d = lsb_first;
    end
  end

  always_comb begin
    tx_pop = ~tx_empty &
             ((tx_q == IDLE) | ((tx_q == STOP) & ttick));
    // line level is registered from the next state so the start
    // bit appears in the same cycle START is entered
    case (tx_d)
      START:   sout_d = START_BIT;
      DATA:    sout_d = tlsb_d ? tsh_d[0] : tsh_d[DATA_W-1];
      STOP:    sout_d = STOP_BIT;
      default: sout_d = IDLE_LEVEL;
    endcase
  end

  assign serial_out  = sout_q;
  assign bus.tx_full = tx_full_w;
  assign bus.tx_busy = (tx_q != IDLE) | ~tx_empty;

  // ---------------- RX ----------------
  state_e            rx_q, rx_d;
  logic              s1_q, s2_q, prev_q;
  logic [DIV_W-1:0]  rcnt_q, rcnt_d;
  logic [DIV_W-1:0]  rdiv_q, rdiv_d;
  logic [BW-1:0]     rbit_q, rbit_d;
  logic [DATA_W-1:0] rsh_q, rsh_d;
  logic              rlsb_q, rlsb_d;
  logic              ovr_q, ovr_d;
  logic              ferr_q, ferr_d;
  logic              rsample, stop_smp, rx_push, rx_full;
  logic              rx_empty_w;
  logic [DIV_W-1:0]  rmid;

  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rx_push),
    .wdata_i (rsh_q),
    .pop_i   (bus.rd_en),
    .rdata_o (bus.rd_data),
    .full_o  (rx_full),
    .empty_o (rx_empty_w)
  );

  // START samples at mid-bit; later samples are one period apart
  assign rmid    = (rx_q == START) ? (rdiv_q >> 1) : rdiv_q;
  assign rsample = (rcnt_q == rmid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q   <= IDLE_LEVEL;
      s2_q   <= IDLE_LEVEL;
      prev_q <= IDLE_LEVEL;
      rx_q   <= IDLE;
      rcnt_q <= '0;
      rdiv_q <= '0;
      rbit_q <= '0;
      rsh_q  <= '0;
      rlsb_q <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s1_q   <= serial_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      rx_q   <= rx_d;
      rcnt_q <= rcnt_d;
      rdiv_q <= rdiv_d;
      rbit_q <= rbit_d;
      rsh_q  <= rsh_d;
      rlsb_q <= rlsb_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  always_comb begin
    rx_d   = rx_q;
    rcnt_d = rcnt_q + 1'b1;
    rdiv_d = rdiv_q;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    rlsb_d = rlsb_q;
    unique case (rx_q)
      IDLE: begin
        rcnt_d = '0;
        if (prev_q & ~s2_q) begin
          rx_d   = START;
          rdiv_d = div;
          rlsb_d = lsb_first;
        end
      end
      START: begin
        if (rsample) begin
          rcnt_d = '0;
          rbit_d = '0;
          rx_d   = s2_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rsample) begin
          rcnt_d = '0;
          rsh_d  = rlsb_q
                 ? ((rsh_q >> 1) | (DATA_W'(s2_q) << (DATA_W - 1)))
                 : ((rsh_q << 1) | DATA_W'(s2_q));
          if (rbit_q == LAST_BIT) rx_d = STOP;
          else rbit_d = rbit_q + 1'b1;
        end
      end
      STOP: begin
        if (rsample) begin
          rcnt_d = '0;
          rx_d   = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    stop_smp = (rx_q == STOP) & rsample;
    rx_push  = stop_smp & s2_q;
    ferr_d   = stop_smp & ~s2_q;
    // a same-cycle pop makes room, so only a true drop sets overrun
    ovr_d    = (rx_push & rx_full & ~bus.rd_en) |
               (ovr_q & ~bus.clr_ovr);
  end

  assign bus.rx_empty   = rx_empty_w;
  assign bus.rx_overrun = ovr_q;
  assign bus.frame_err  = ferr_q;

endmodule
